// File: rtl/bus_demux_collector.sv
// bus_demux_collector: steers a valid/ready word stream into CHANNELS slot
// registers (sequential or addressed) and presents a completed frame as one
// packed bus laid out like the mux input.
module bus_demux_collector #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned BUS_SIZE = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         mode,
   input  logic [CHANNELS-1:0]          selector,
   input  logic [BUS_SIZE-1:0]          data_in,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [CHANNELS*BUS_SIZE-1:0] data_out,
   output logic [CHANNELS-1:0]          channel_valid,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         error
);

   localparam int unsigned IDX_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_t;

   state_t              state;
   state_t              state_n;
   logic [IDX_W-1:0]    index;
   logic [IDX_W-1:0]    index_n;
   logic [CHANNELS-1:0] valid_n;
   logic                error_n;
   logic                write_en;
   logic [CHANNELS-1:0] target;
   logic [CHANNELS-1:0] target_oh;

   // Handshake flags depend on state only
   assign in_ready  = (state == COLLECT);
   assign out_valid = (state == FULL);

   // Target slot decode; an out-of-range target yields an all-zero one-hot
   always_comb begin
      target    = mode ? selector : CHANNELS'(index);
      target_oh = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         target_oh[i] = (target == CHANNELS'(i));
      end
   end

   // Next-state, index, slot-valid and error computation
   always_comb begin
      state_n  = state;
      index_n  = index;
      valid_n  = channel_valid;
      error_n  = 1'b0;
      write_en = 1'b0;
      case (state)
         COLLECT: begin
            if (in_valid) begin
               write_en = 1'b1;
               error_n  = (~|target_oh) | (|(target_oh & channel_valid));
               valid_n  = channel_valid | target_oh;
               if (!mode) begin
                  index_n = (index == LAST_IDX) ? '0 : index + IDX_W'(1);
               end
               if (&valid_n) begin
                  state_n = FULL;
               end
            end
         end
         FULL: begin
            if (out_ready) begin
               valid_n = '0;
               index_n = '0;
               state_n = COLLECT;
            end
         end
         default: state_n = COLLECT;
      endcase
      // Frame abort overrides everything except the slot write itself
      if (flush) begin
         valid_n = '0;
         index_n = '0;
         state_n = COLLECT;
         error_n = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= COLLECT;
      end else begin
         state <= state_n;
      end
   end

   // Index, slot-valid flags and error pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         index         <= '0;
         channel_valid <= '0;
         error         <= 1'b0;
      end else begin
         index         <= index_n;
         channel_valid <= valid_n;
         error         <= error_n;
      end
   end

   // Slot storage; contents persist across handshakes and flushes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (write_en && target_oh[i]) begin
               data_out[BUS_SIZE*i +: BUS_SIZE] <= data_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_bus_demux_collector.sv
// Scoreboard bench for bus_demux_collector: driver runs a behavioural model
// and queues expected observations; a monitor pops and compares them.
module tb_bus_demux_collector;

   localparam int unsigned CH = 4;
   localparam int unsigned BS = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            flush = 1'b0;
   logic            mode = 1'b0;
   logic [CH-1:0]   selector = '0;
   logic [BS-1:0]   data_in = '0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic            in_ready;
   logic [CH*BS-1:0] data_out;
   logic [CH-1:0]   channel_valid;
   logic            out_valid;
   logic            error;

   always #5 clk = ~clk;

   bus_demux_collector #(.CHANNELS(CH), .BUS_SIZE(BS)) dut (
      .clk(clk), .reset(reset), .flush(flush), .mode(mode),
      .selector(selector), .data_in(data_in), .in_valid(in_valid),
      .in_ready(in_ready), .data_out(data_out), .channel_valid(channel_valid),
      .out_valid(out_valid), .out_ready(out_ready), .error(error)
   );

   typedef struct packed {
      logic [31:0] dout;
      logic [3:0]  cv;
      logic        ov;
      logic        ir;
      logic        err;
   } obs_t;

   obs_t        exp_q[$];
   logic [31:0] frame_q[$];
   int          checks = 0;
   int          passes = 0;
   bit          run = 1'b0;
   bit          prev_ov = 1'b0;

   // Reference model state: frame contents, per-slot written flags, index
   logic [7:0]  m_slot[CH];
   bit          m_vld[CH];
   int          m_idx = 0;
   bit          m_full = 1'b0;
   bit          m_err = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] model_bus();
      logic [31:0] r;
      for (int i = 0; i < CH; i++) r[8*i +: 8] = m_slot[i];
      return r;
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.dout = model_bus();
      for (int i = 0; i < CH; i++) o.cv[i] = m_vld[i];
      o.ov  = m_full;
      o.ir  = !m_full;
      o.err = m_err;
      return o;
   endfunction

   function automatic bit all_valid();
      for (int i = 0; i < CH; i++) if (!m_vld[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Drive one cycle of inputs, advance the model, queue the expectation
   task automatic beat(input bit v, input bit m, input int sel, input logic [7:0] d,
                       input bit ordy, input bit fl);
      bit was_full;
      int t;
      in_valid = v; mode = m; selector = CH'(sel); data_in = d;
      out_ready = ordy; flush = fl;
      if (reset) begin
         for (int i = 0; i < CH; i++) begin m_slot[i] = 8'h00; m_vld[i] = 1'b0; end
         m_idx = 0; m_full = 1'b0; m_err = 1'b0;
      end else begin
         was_full = m_full;
         m_err = 1'b0;
         if (!was_full && v) begin
            t = m ? sel : m_idx;
            if (t < CH) begin
               if (m_vld[t]) m_err = 1'b1;
               m_slot[t] = d;
               m_vld[t] = 1'b1;
            end else begin
               m_err = 1'b1;
            end
            if (!m) m_idx = (m_idx + 1) % CH;
            if (all_valid()) m_full = 1'b1;
         end else if (was_full && ordy) begin
            for (int i = 0; i < CH; i++) m_vld[i] = 1'b0;
            m_idx = 0; m_full = 1'b0;
         end
         if (fl) begin
            for (int i = 0; i < CH; i++) m_vld[i] = 1'b0;
            m_idx = 0; m_full = 1'b0; m_err = 1'b0;
         end else if (!was_full && m_full) begin
            frame_q.push_back(model_bus());
         end
      end
      exp_q.push_back(model_obs());
      @(negedge clk);
   endtask

   task automatic reset_checks();
      check("rst_data_out", 64'(data_out), 64'h0);
      check("rst_channel_valid", 64'(channel_valid), 64'h0);
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_in_ready", 64'(in_ready), 64'h1);
      check("rst_error", 64'(error), 64'h0);
   endtask

   // Monitor: per-cycle status against the queue, frames on out_valid rise
   initial begin
      obs_t a;
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (run) begin
            a = {data_out, channel_valid, out_valid, in_ready, error};
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL sb_underflow: got no expectation for status %h", a);
            end else begin
               e = exp_q.pop_front();
               check("cycle_status", 64'(a), 64'(e));
            end
            if (out_valid && !prev_ov) begin
               if (frame_q.size() == 0) begin
                  checks++;
                  $display("FAIL frame_unexpected: got %h expected no frame", data_out);
               end else begin
                  check("frame_data", 64'(data_out), 64'(frame_q.pop_front()));
               end
            end
            prev_ov = out_valid;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      reset_checks();
      @(negedge clk);
      @(negedge clk);
      run = 1'b1;
      beat(0, 0, 0, 8'h00, 0, 0);
      reset = 1'b0;

      // Sequential stream with immediate consumption
      beat(1, 0, 0, 8'h11, 1, 0);
      check("seq_cv1", 64'(channel_valid), 64'h1);
      beat(1, 0, 0, 8'h22, 1, 0);
      check("seq_cv2", 64'(channel_valid), 64'h3);
      beat(1, 0, 0, 8'h33, 1, 0);
      check("seq_cv3", 64'(channel_valid), 64'h7);
      beat(1, 0, 0, 8'h44, 1, 0);
      check("seq_frame", 64'(data_out), 64'h44332211);
      check("seq_out_valid", 64'(out_valid), 64'h1);
      check("seq_in_ready", 64'(in_ready), 64'h0);
      beat(1, 0, 0, 8'h55, 1, 0);
      check("seq_handshake", 64'(out_valid), 64'h0);
      beat(1, 0, 0, 8'h66, 1, 0);
      check("seq_next_frame", 64'(channel_valid), 64'h1);
      beat(0, 0, 0, 8'h00, 0, 1);

      // Backpressure
      beat(1, 0, 0, 8'hA1, 0, 0);
      beat(1, 0, 0, 8'hA2, 0, 0);
      beat(1, 0, 0, 8'hA3, 0, 0);
      beat(1, 0, 0, 8'hA4, 0, 0);
      for (int i = 0; i < 5; i++) beat(1, 0, 0, 8'hEE, 0, 0);
      check("bp_hold_data", 64'(data_out), 64'hA4A3A2A1);
      check("bp_hold_valid", 64'(out_valid), 64'h1);
      beat(1, 0, 0, 8'hB0, 1, 0);
      beat(1, 0, 0, 8'hB1, 0, 0);
      check("bp_restart_slot0", 64'(data_out), 64'hA4A3A2B1);
      beat(0, 0, 0, 8'h00, 0, 1);

      // Addressed writes
      beat(1, 1, 3, 8'hD3, 0, 0);
      check("addr_cv1", 64'(channel_valid), 64'h8);
      beat(1, 1, 1, 8'hD1, 0, 0);
      beat(1, 1, 0, 8'hD0, 0, 0);
      beat(1, 1, 2, 8'hD2, 0, 0);
      check("addr_frame", 64'(data_out), 64'hD3D2D1D0);
      check("addr_out_valid", 64'(out_valid), 64'h1);
      beat(0, 1, 0, 8'h00, 1, 0);

      // Duplicate and out-of-range addressed beats
      beat(1, 1, 1, 8'h55, 0, 0);
      beat(1, 1, 1, 8'h66, 0, 0);
      check("dup_error", 64'(error), 64'h1);
      check("dup_slot1", 64'(data_out[15:8]), 64'h66);
      beat(1, 1, 4, 8'h77, 0, 0);
      check("oor_error", 64'(error), 64'h1);
      check("oor_cv", 64'(channel_valid), 64'h2);
      beat(0, 1, 0, 8'h00, 0, 0);
      check("err_clear", 64'(error), 64'h0);
      beat(0, 0, 0, 8'h00, 0, 1);

      // Flush keeps slot data
      beat(1, 0, 0, 8'h01, 0, 0);
      beat(1, 0, 0, 8'h02, 0, 0);
      beat(0, 0, 0, 8'h00, 0, 1);
      check("flush_cv", 64'(channel_valid), 64'h0);
      check("flush_keep", 64'(data_out[15:0]), 64'h0201);
      beat(1, 0, 0, 8'h0A, 0, 0);
      beat(1, 0, 0, 8'h0B, 0, 0);
      beat(1, 0, 0, 8'h0C, 0, 0);
      beat(1, 0, 0, 8'h0D, 0, 0);
      check("flush_next_frame", 64'(data_out), 64'h0D0C0B0A);
      beat(0, 0, 0, 8'h00, 1, 0);

      // Flush colliding with the completing beat
      beat(1, 0, 0, 8'h31, 0, 0);
      beat(1, 0, 0, 8'h32, 0, 0);
      beat(1, 0, 0, 8'h33, 0, 0);
      beat(1, 0, 0, 8'h34, 0, 1);
      check("flush_win_valid", 64'(out_valid), 64'h0);
      check("flush_win_data", 64'(data_out), 64'h34333231);

      // Asynchronous reset mid-frame
      beat(1, 0, 0, 8'h01, 1, 0);
      beat(1, 0, 0, 8'h02, 1, 0);
      #2;
      reset = 1'b1;
      #1;
      reset_checks();
      beat(0, 0, 0, 8'h00, 0, 0);
      reset = 1'b0;
      beat(1, 0, 0, 8'h21, 0, 0);
      beat(1, 0, 0, 8'h22, 0, 0);
      beat(1, 0, 0, 8'h23, 0, 0);
      beat(1, 0, 0, 8'h24, 0, 0);
      check("post_rst_frame", 64'(data_out), 64'h24232221);
      beat(0, 0, 0, 8'h00, 1, 0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         beat($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 5)), 8'($urandom),
              $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      end

      run = 1'b0;
      check("exp_q_drained", 64'(exp_q.size()), 64'h0);
      check("frame_q_drained", 64'(frame_q.size()), 64'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
